// File: rtl/uart_rx_if.sv
// Consumer-side bundle of uart_rx: received byte, valid/read handshake and sticky error flags.
// UART_RX_PARITY_EN adds the parity_err_o flag.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_o;
   logic                 data_valid_o;
   logic                 data_re_i;
   logic                 rx_done;
   logic                 frame_err_o;
   logic                 overrun_o;
   logic                 err_clr_i;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err_o;
`endif

   modport master (
      output data_o, data_valid_o, rx_done, frame_err_o, overrun_o,
`ifdef UART_RX_PARITY_EN
      output parity_err_o,
`endif
      input  data_re_i, err_clr_i
   );

   modport slave (
      input  data_o, data_valid_o, rx_done, frame_err_o, overrun_o,
`ifdef UART_RX_PARITY_EN
      input  parity_err_o,
`endif
      output data_re_i, err_clr_i
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, counting x16 oversample tick rising edges in the clk_master domain.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds a sticky parity error flag.
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_master,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       rx_en,
   input  logic       tick,
   uart_rx_if.master  bus
);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               r_state, w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                 r_tick_d;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   logic [BIT_W-1:0]     r_bit_idx, w_bit_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_done, r_frame_err, r_overrun;
   logic                 w_rxs, w_tick_ev, w_cnt_last;
   logic                 w_shift_en, w_commit, w_frame_err;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit, r_parity_err;
   logic                 w_par_en, w_par_err, w_par_ok;
`endif

   assign w_rxs      = r_sync[SYNC_STAGES-1];
   assign w_tick_ev  = tick & ~r_tick_d;
   assign w_cnt_last = (r_cnt == CNT_W'(OVERSAMPLE - 1));
`ifdef UART_RX_PARITY_EN
   assign w_par_ok   = ~(^{r_shift, r_par_bit});
`endif

   always_ff @(posedge clk_master) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Mid-bit sampling: START waits half a bit, every later bit waits a full bit of tick events.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_bit_next   = r_bit_idx;
      w_shift_en   = 1'b0;
      w_commit     = 1'b0;
      w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_en     = 1'b0;
      w_par_err    = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (rx_en && !w_rxs) begin
               w_state_next = S_START;
               w_cnt_next   = '0;
            end
         end
         S_START: begin
            if (w_tick_ev) begin
               if (r_cnt == CNT_W'(OVERSAMPLE/2 - 1)) begin
                  w_cnt_next   = '0;
                  w_bit_next   = '0;
                  w_state_next = w_rxs ? S_IDLE : S_DATA;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         S_DATA: begin
            if (w_tick_ev) begin
               if (w_cnt_last) begin
                  w_cnt_next = '0;
                  w_shift_en = 1'b1;
                  if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     w_state_next = S_PARITY;
`else
                     w_state_next = S_STOP;
`endif
                  end else begin
                     w_bit_next = r_bit_idx + BIT_W'(1);
                  end
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick_ev) begin
               if (w_cnt_last) begin
                  w_cnt_next   = '0;
                  w_par_en     = 1'b1;
                  w_state_next = S_STOP;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (w_tick_ev) begin
               if (w_cnt_last) begin
                  w_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                  w_par_err  = ~w_par_ok;
                  w_commit   = w_rxs & w_par_ok;
`else
                  w_commit   = w_rxs;
`endif
                  w_frame_err  = ~w_rxs;
                  w_state_next = w_rxs ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (w_rxs) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      // Disabling mid-frame silently drops the partial byte.
      if (r_state != S_IDLE && !rx_en) begin
         w_state_next = S_IDLE;
         w_shift_en   = 1'b0;
         w_commit     = 1'b0;
         w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
         w_par_en     = 1'b0;
         w_par_err    = 1'b0;
`endif
      end
   end

   // A commit beats a same-cycle read, and a new error beats a same-cycle clear.
   always_ff @(posedge clk_master) begin
      if (rst_i) begin
         r_sync      <= '1;
         r_tick_d    <= 1'b0;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
         r_tick_d  <= tick;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_next;
         r_done    <= w_commit;
         if (w_shift_en) r_shift[r_bit_idx] <= w_rxs;
         if (w_commit) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (bus.data_re_i) begin
            r_valid <= 1'b0;
         end
         if (w_commit && r_valid && !bus.data_re_i) r_overrun <= 1'b1;
         else if (bus.err_clr_i)                    r_overrun <= 1'b0;
         if (w_frame_err)                           r_frame_err <= 1'b1;
         else if (bus.err_clr_i)                    r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (w_par_en) r_par_bit <= w_rxs;
         if (w_par_err)                             r_parity_err <= 1'b1;
         else if (bus.err_clr_i)                    r_parity_err <= 1'b0;
`endif
      end
   end

   assign bus.data_o       = r_data;
   assign bus.data_valid_o = r_valid;
   assign bus.rx_done      = r_done;
   assign bus.frame_err_o  = r_frame_err;
   assign bus.overrun_o    = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err_o = r_parity_err;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected bytes queued for a rx_done monitor.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
   localparam int TICK_HALF = 8;
   localparam int BIT_CLKS  = 16 * 2 * TICK_HALF;

   logic clk, rst, rx, rxEn, tick;
   int   compared   = 0;
   int   mismatched = 0;
   int   doneCount  = 0;
   int   savedDone;
   logic [7:0] expQ[$];

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .clk_master (clk),
      .rst_i      (rst),
      .rx_i       (rx),
      .rx_en      (rxEn),
      .tick       (tick),
      .bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick = 1'b0;
      forever begin
         repeat (TICK_HALF) @(posedge clk);
         #1 tick = ~tick;
      end
   end

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One frame: start, data LSB first, optional parity, stop level held stopLen bits, then idle.
   task automatic applyStimulus(input logic [7:0] b, input logic parBit, input int stopLen,
                                input logic stopLevel, input int dropEnAt);
      rx = 1'b0;
      waitClk(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == dropEnAt) begin
            waitClk(BIT_CLKS / 2);
            rxEn = 1'b0;
            waitClk(BIT_CLKS - BIT_CLKS / 2);
         end else begin
            waitClk(BIT_CLKS);
         end
      end
`ifdef UART_RX_PARITY_EN
      rx = parBit;
      waitClk(BIT_CLKS);
`endif
      rx = stopLevel;
      waitClk(BIT_CLKS * stopLen);
      rx = 1'b1;
      waitClk(BIT_CLKS * 2);
   endtask

   task automatic ackAll();
      bus.data_re_i = 1'b1;
      bus.err_clr_i = 1'b1;
      waitClk(1);
      bus.data_re_i = 1'b0;
      bus.err_clr_i = 1'b0;
      waitClk(1);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rx_done) begin
         doneCount++;
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_rx_done: got byte 0x%0h, expected no commit", bus.data_o);
         end else begin
            checkOutput("rx_data", {24'd0, bus.data_o}, {24'd0, expQ.pop_front()});
            checkOutput("rx_valid_at_done", {31'd0, bus.data_valid_o}, 32'd1);
         end
      end
   end

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      rxEn = 1'b0;
      bus.data_re_i = 1'b0;
      bus.err_clr_i = 1'b0;
      waitClk(4);
      checkOutput("reset_data", {24'd0, bus.data_o}, 32'd0);
      checkOutput("reset_valid", {31'd0, bus.data_valid_o}, 32'd0);
      checkOutput("reset_done", {31'd0, bus.rx_done}, 32'd0);
      checkOutput("reset_ferr", {31'd0, bus.frame_err_o}, 32'd0);
      checkOutput("reset_ovr", {31'd0, bus.overrun_o}, 32'd0);
`ifdef UART_RX_PARITY_EN
      checkOutput("reset_perr", {31'd0, bus.parity_err_o}, 32'd0);
`endif
      rst = 1'b0;
      rxEn = 1'b1;
      waitClk(BIT_CLKS);

      $display("[TB] frame 0xDA");
      expQ.push_back(8'hDA);
      applyStimulus(8'hDA, 1'b1, 1, 1'b1, -1);
      checkOutput("da_data", {24'd0, bus.data_o}, 32'hDA);
      checkOutput("da_valid", {31'd0, bus.data_valid_o}, 32'd1);
      checkOutput("da_done_count", doneCount, 32'd1);
      checkOutput("da_ferr", {31'd0, bus.frame_err_o}, 32'd0);
      checkOutput("da_ovr", {31'd0, bus.overrun_o}, 32'd0);

      $display("[TB] frame 0x2D unread -> overrun");
      expQ.push_back(8'h2D);
      applyStimulus(8'h2D, 1'b0, 1, 1'b1, -1);
      checkOutput("2d_data", {24'd0, bus.data_o}, 32'h2D);
      checkOutput("2d_ovr", {31'd0, bus.overrun_o}, 32'd1);
      ackAll();
      checkOutput("clr_ovr", {31'd0, bus.overrun_o}, 32'd0);
      checkOutput("clr_valid", {31'd0, bus.data_valid_o}, 32'd0);

      $display("[TB] frame 0x55 with long low stop");
      savedDone = doneCount;
      applyStimulus(8'h55, 1'b0, 20, 1'b0, -1);
      checkOutput("55_ferr", {31'd0, bus.frame_err_o}, 32'd1);
      checkOutput("55_no_done", doneCount, savedDone);
      checkOutput("55_data_held", {24'd0, bus.data_o}, 32'h2D);
      checkOutput("55_valid", {31'd0, bus.data_valid_o}, 32'd0);
      expQ.push_back(8'hA3);
      applyStimulus(8'hA3, 1'b0, 1, 1'b1, -1);
      checkOutput("a3_data", {24'd0, bus.data_o}, 32'hA3);
      checkOutput("a3_ferr_sticky", {31'd0, bus.frame_err_o}, 32'd1);
      checkOutput("a3_ovr", {31'd0, bus.overrun_o}, 32'd0);
      ackAll();
      checkOutput("clr_ferr", {31'd0, bus.frame_err_o}, 32'd0);

      $display("[TB] idle-line glitch");
      savedDone = doneCount;
      rx = 1'b0;
      waitClk(4 * 2 * TICK_HALF);
      rx = 1'b1;
      waitClk(BIT_CLKS * 2);
      checkOutput("glitch_no_done", doneCount, savedDone);
      checkOutput("glitch_ferr", {31'd0, bus.frame_err_o}, 32'd0);
      checkOutput("glitch_ovr", {31'd0, bus.overrun_o}, 32'd0);

      $display("[TB] abort 0xF0 at bit 3, then 0x0F");
      applyStimulus(8'hF0, 1'b0, 1, 1'b1, 3);
      rxEn = 1'b1;
      waitClk(BIT_CLKS);
      checkOutput("abort_no_done", doneCount, savedDone);
      checkOutput("abort_ferr", {31'd0, bus.frame_err_o}, 32'd0);
      expQ.push_back(8'h0F);
      applyStimulus(8'h0F, 1'b0, 1, 1'b1, -1);
      checkOutput("0f_data", {24'd0, bus.data_o}, 32'h0F);
      checkOutput("0f_done_count", doneCount, savedDone + 1);
      checkOutput("0f_ovr", {31'd0, bus.overrun_o}, 32'd0);
      ackAll();

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity frames 0x07");
      expQ.push_back(8'h07);
      applyStimulus(8'h07, 1'b1, 1, 1'b1, -1);
      checkOutput("par_ok_data", {24'd0, bus.data_o}, 32'h07);
      checkOutput("par_ok_perr", {31'd0, bus.parity_err_o}, 32'd0);
      ackAll();
      savedDone = doneCount;
      applyStimulus(8'h07, 1'b0, 1, 1'b1, -1);
      checkOutput("par_bad_perr", {31'd0, bus.parity_err_o}, 32'd1);
      checkOutput("par_bad_no_done", doneCount, savedDone);
      checkOutput("par_bad_valid", {31'd0, bus.data_valid_o}, 32'd0);
      ackAll();
      checkOutput("par_clr", {31'd0, bus.parity_err_o}, 32'd0);
`endif

      checkOutput("queue_drained", expQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
